data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit words stored.
REQ-002 Parameter AW, default 10: word-index width; SHALL equal clog2(DEPTH).
REQ-003 Parameter DW, default 32: data word width.
REQ-004 clk_dm  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low, sampled on rising clk_dm.
REQ-006 Mem_Write  input  1  write enable, active-high.
REQ-007 DM_Addr  input  32  word index, not a byte address; bits [AW-1:0] select the word.
REQ-008 M_W_Data  input  DW  write data.
REQ-009 M_R_Data  output  DW  read data.
REQ-010 init_done  output  1  high once the post-reset clear sweep has completed.

Function
REQ-011 Storage SHALL be DEPTH words of DW bits, held in a single array.
REQ-012 Reads SHALL be combinational: M_R_Data follows DM_Addr and array contents within the same cycle, with no clock latency.
REQ-013 A write SHALL occur on a rising clk_dm when Mem_Write=1, rst_n=1, init_done=1 and the address is in range.
- Effect: mem[DM_Addr[AW-1:0]] <= M_W_Data.
REQ-014 In-range address SHALL mean DM_Addr[31:AW] == 0.
- Out-of-range read: M_R_Data = 0.
- Out-of-range write: ignored, no aliasing into the array.
REQ-015 Read-during-write to the same address SHALL return the old data until the clock edge and the new data immediately after it.
REQ-016 Writes SHALL be full-word only; there are no byte enables.
REQ-017 While init_done=0, M_R_Data SHALL be 0 and all writes SHALL be ignored.
REQ-018 Array contents SHALL be all-zero at time 0 in simulation, so reads before any reset return 0.
REQ-019 init_done SHALL be 1 at time 0.
REQ-020 Mem_Write asserted together with rst_n=0 SHALL be ignored.

Reset
REQ-021 rst_n=0 at a rising edge SHALL set init_done=0 and set the clear pointer to 0.
REQ-022 After rst_n returns to 1, the block SHALL zero one word per cycle, index 0 to DEPTH-1.
REQ-023 init_done SHALL rise on the cycle after word DEPTH-1 is cleared, i.e. DEPTH cycles after reset release.
REQ-024 rst_n reasserted mid-sweep SHALL restart the sweep from index 0.
REQ-025 Reset SHALL NOT be asynchronous, and the clock SHALL NOT be gated.

Structure
REQ-026 DEPTH, AW and DW defaults SHALL live in a shared package dm_pkg, alongside the CPU's other memory constants.
REQ-027 The clear-sweep counter and FSM SHALL be a sub-module dm_clear_seq.
- States: CLEAR and READY.
- Outputs: clear index, clear write-strobe, init_done.
REQ-028 The array and the read/write muxing SHALL be implemented in data_mem itself.

Verification
REQ-029 Power-up: sweep DM_Addr 0..1023, one value per 10 ns clock period, with no writes -> M_R_Data = 0 at every address.
REQ-030 Write then read back:
- Write 0xDEADBEEF to index 5 and 0x12345678 to index 1023.
- Then read -> those values at indices 5 and 1023, 0 at index 4 and index 6.
REQ-031 Out of range: write 0xFFFFFFFF at DM_Addr=0x400 -> index 0 unchanged, and reading 0x400 returns 0.
REQ-032 Same-address read-during-write: index 7 holds 0x1, then write 0x2 -> 0x1 before the edge, 0x2 after it.
REQ-033 Reset: write 0xA5A5A5A5 to index 3, then pulse rst_n low for one cycle.
- init_done = 0 for 1024 cycles and writes are ignored in that window.
- After init_done rises, index 3 reads 0.
REQ-034 Reset reasserted at clear index 500 -> init_done rises exactly 1024 cycles after the final reset release.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared memory constants for the CPU's data/instruction memories and the
// clear-sweep state type used by the data memory.
package dm_pkg;

    localparam int DM_DEPTH       = 1024;
    localparam int DM_AW          = 10;
    localparam int DM_DW          = 32;
    localparam int IM_DEPTH       = 1024;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    // A word index is in range only when every bit above the index field is zero.
    function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
        return (addr >> aw) == 32'd0;
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// Data-memory port bundle: the CPU drives address/data/enable, the memory
// returns read data and its init_done status.
interface data_mem_if #(
    parameter int DW = 32
);

    logic          Mem_Write;
    logic [31:0]   DM_Addr;
    logic [DW-1:0] M_W_Data;
    logic [DW-1:0] M_R_Data;
    logic          init_done;

    modport master (
        output Mem_Write, DM_Addr, M_W_Data,
        input  M_R_Data, init_done
    );

    modport slave (
        input  Mem_Write, DM_Addr, M_W_Data,
        output M_R_Data, init_done
    );

endinterface

// File: rtl/dm_clear_seq.sv
// Post-reset clear sequencer: walks the word index 0..DEPTH-1 one word per
// cycle, then raises init_done and stays READY until the next reset.
module dm_clear_seq
    import dm_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH,
    parameter int AW    = DM_AW
) (
    input  logic          clk_dm,
    input  logic          rst_n,
    output logic [AW-1:0] clear_idx,
    output logic          clear_we,
    output logic          init_done
);

    // Power-up values make the memory usable before any reset is applied.
    clr_state_t    state    = READY;
    clr_state_t    state_next;
    logic [AW-1:0] idx      = '0;
    logic [AW-1:0] idx_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_dm) begin
        if (!rst_n) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            CLEAR: begin
                if (idx == AW'(DEPTH - 1)) begin
                    state_next = READY;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + AW'(1);
                end
            end
            READY:   state_next = READY;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        clear_idx = idx;
        clear_we  = (state == CLEAR);
        init_done = (state == READY);
    end

endmodule

// File: rtl/data_mem.sv
// Word-addressed data memory with combinational read, gated full-word write
// and a one-word-per-cycle zeroing sweep after every reset.
module data_mem
    import dm_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH,
    parameter int AW    = DM_AW,
    parameter int DW    = DM_DW
) (
    input  logic       clk_dm,
    input  logic       rst_n,
    data_mem_if.slave  bus
);

    logic [DW-1:0] mem [DEPTH] = '{default: '0};

    logic [AW-1:0] clear_idx;
    logic          clear_we;
    logic          init_done;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          wr_en;

    dm_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk_dm    (clk_dm),
        .rst_n     (rst_n),
        .clear_idx (clear_idx),
        .clear_we  (clear_we),
        .init_done (init_done)
    );

    assign word_idx = bus.DM_Addr[AW-1:0];
    assign in_range = addr_in_range(bus.DM_Addr, AW);
    assign wr_en    = bus.Mem_Write && init_done && in_range;

    // NOTE: the array has no reset term; it is zeroed word by word by the
    // clear sweep so it still maps onto plain RAM.
    always_ff @(posedge clk_dm) begin
        if (rst_n) begin
            if (clear_we) begin
                mem[clear_idx] <= '0;
            end else if (wr_en) begin
                mem[word_idx] <= bus.M_W_Data;
            end
        end
    end

    // Old data is visible until the write edge since the read is purely combinational.
    always_comb begin
        bus.M_R_Data = '0;
        if (init_done && in_range) begin
            bus.M_R_Data = mem[word_idx];
        end
    end

    assign bus.init_done = init_done;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: power-up contents, write/read-back,
// out-of-range handling, read-during-write and the post-reset clear sweep.
module tb_data_mem;

    localparam int DEPTH = 1024;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] exp;
    } rd_item_t;

    logic clk_dm = 1'b0;
    logic rst_n  = 1'b1;

    data_mem_if #(.DW(32)) bus ();

    data_mem dut (
        .clk_dm (clk_dm),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_dm = ~clk_dm;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [DEPTH];
    logic        model_ready = 1'b1;
    rd_item_t    exp_q [$];

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (model_ready && a[31:10] == 22'd0) return model[a[9:0]];
        return 32'd0;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_dm);
        bus.Mem_Write = 1'b1;
        bus.DM_Addr   = a;
        bus.M_W_Data  = d;
        @(posedge clk_dm);
        if (rst_n && model_ready && a[31:10] == 22'd0) model[a[9:0]] = d;
        #1;
        bus.Mem_Write = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input string name);
        rd_item_t it;
        @(negedge clk_dm);
        bus.DM_Addr = a;
        it.name = name;
        it.addr = a;
        it.exp  = model_read(a);
        exp_q.push_back(it);
        #2;
        it = exp_q.pop_front();
        total++;
        if (bus.M_R_Data !== it.exp) begin
            bad++;
            $display("FAIL %s addr=%h got=%h expected=%h", it.name, it.addr, bus.M_R_Data, it.exp);
        end
    endtask

    // Counts rising edges after release until init_done is seen high.
    task automatic wait_init(input string name, input int expected_edges);
        int n = 0;
        bit seen = 0;
        for (int i = 1; i <= 2 * DEPTH; i++) begin
            @(posedge clk_dm);
            #1;
            if (bus.init_done === 1'b1) begin
                n = i;
                seen = 1;
                bus.Mem_Write = 1'b0;
                break;
            end
        end
        total++;
        if (!seen || n != expected_edges) begin
            bad++;
            $display("FAIL %s init_done edges got=%0d expected=%0d seen=%0d", name, n, expected_edges, seen);
        end
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (bus.init_done !== 1'b1) begin
            bad++;
            $display("FAIL time0_init_done got=%b expected=1", bus.init_done);
        end
    endtask

    task automatic test_powerup;
        for (int i = 0; i < DEPTH; i++) do_read(32'(i), "powerup_zero");
    endtask

    task automatic test_write_read;
        do_write(32'd5, 32'hDEADBEEF);
        do_write(32'd1023, 32'h12345678);
        do_read(32'd5, "wr_idx5");
        do_read(32'd1023, "wr_idx1023");
        do_read(32'd4, "wr_idx4");
        do_read(32'd6, "wr_idx6");
    endtask

    task automatic test_out_of_range;
        do_write(32'h400, 32'hFFFFFFFF);
        do_write(32'h8000_0005, 32'hFFFFFFFF);
        do_read(32'd0, "oor_idx0");
        do_read(32'h400, "oor_read400");
        do_read(32'd5, "oor_idx5");
        do_read(32'hFFFF_FC05, "oor_readhigh");
    endtask

    task automatic test_rdw;
        do_write(32'd7, 32'h1);
        @(negedge clk_dm);
        bus.Mem_Write = 1'b1;
        bus.DM_Addr   = 32'd7;
        bus.M_W_Data  = 32'h2;
        #2;
        total++;
        if (bus.M_R_Data !== 32'h1) begin
            bad++;
            $display("FAIL rdw_before got=%h expected=%h", bus.M_R_Data, 32'h1);
        end
        @(posedge clk_dm);
        #1;
        bus.Mem_Write = 1'b0;
        model[7] = 32'h2;
        total++;
        if (bus.M_R_Data !== 32'h2) begin
            bad++;
            $display("FAIL rdw_after got=%h expected=%h", bus.M_R_Data, 32'h2);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) do_write(32'(10 + i), 32'hC0DE_0000 + 32'(i * 3));
        for (int i = 0; i < 8; i++) do_read(32'(10 + i), "b2b");
    endtask

    task automatic test_reset_sweep;
        do_write(32'd3, 32'hA5A5A5A5);
        do_read(32'd3, "pre_reset_idx3");
        // Reset edge with a write pending: the write must be dropped.
        @(negedge clk_dm);
        rst_n         = 1'b0;
        bus.Mem_Write = 1'b1;
        bus.DM_Addr   = 32'd9;
        bus.M_W_Data  = 32'h77;
        @(posedge clk_dm);
        #1;
        model_ready = 1'b0;
        total++;
        if (bus.init_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_init_low got=%b expected=0", bus.init_done);
        end
        @(negedge clk_dm);
        rst_n        = 1'b1;
        bus.DM_Addr  = 32'd3;
        bus.M_W_Data = 32'h5555_5555;
        #2;
        total++;
        if (bus.M_R_Data !== 32'd0) begin
            bad++;
            $display("FAIL sweep_read_zero got=%h expected=%h", bus.M_R_Data, 32'd0);
        end
        wait_init("reset_sweep", DEPTH);
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        model_ready = 1'b1;
        do_read(32'd3, "post_reset_idx3");
        do_read(32'd9, "post_reset_idx9");
        do_read(32'd1023, "post_reset_idx1023");
    endtask

    task automatic test_reset_mid_sweep;
        do_write(32'd600, 32'hCAFEF00D);
        @(negedge clk_dm);
        rst_n = 1'b0;
        @(negedge clk_dm);
        rst_n = 1'b1;
        model_ready = 1'b0;
        repeat (500) @(posedge clk_dm);
        #1;
        total++;
        if (bus.init_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_sweep_init got=%b expected=0", bus.init_done);
        end
        @(negedge clk_dm);
        rst_n = 1'b0;
        @(negedge clk_dm);
        rst_n = 1'b1;
        wait_init("mid_sweep_restart", DEPTH);
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        model_ready = 1'b1;
        do_read(32'd600, "mid_sweep_idx600");
        do_write(32'd600, 32'h0BADF00D);
        do_read(32'd600, "mid_sweep_rewrite");
    endtask

    initial begin
        bus.Mem_Write = 1'b0;
        bus.DM_Addr   = 32'd0;
        bus.M_W_Data  = 32'd0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        test_reset();
        test_powerup();
        test_write_read();
        test_out_of_range();
        test_rdw();
        test_back_to_back();
        test_reset_sweep();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
